agree_btb_assoc: RTL and testbench
==================================

// Module: agree_btb_assoc
// PURPOSE
//  Set-associative branch target buffer for the agree predictor. It is looked up in
//  IF with the fetch PC and written from EX on resolved branches. Each way holds a
//  tag, a target, a valid bit and a fixed agree bias bit. Victims are chosen first
//  invalid, then round-robin, and a sequenced flush FSM invalidates the table.
// PARAMETERS
//  INDEX_WIDTH  6  set index bits; TABLE_SIZE = 2**INDEX_WIDTH sets
//  WAYS         2  ways per set; legal values 1, 2, 4
//  (derived) TAG_WIDTH = 32-INDEX_WIDTH-2; WAY_W = max(1, $clog2(WAYS))
// PORTS
//  clk_i        in   1          clock, rising edge
//  rst_ni       in   1          asynchronous active-low reset
//  rd_pc_i      in   32         fetch PC to look up
//  wren_i       in   1          write/allocate request (resolved taken branch)
//  wr_pc_i      in   32         PC of the resolved branch
//  wr_target_i  in   32         resolved target
//  br_taken_i   in   1          resolved direction; becomes bias on allocation
//  flush_i      in   1          start full-table invalidation
//  hit_o        out  1          valid tag match in the read set
//  rd_target_o  out  32         target of the hit way; 0 when hit_o=0
//  bias_o       out  1          bias of the hit way; 0 when hit_o=0
//  hit_way_o    out  WAY_W      way index of the hit; 0 when hit_o=0
//  busy_o       out  1          flush in progress
// BEHAVIOUR
//  - Address split: index = pc[INDEX_WIDTH+1:2], tag = pc[31:INDEX_WIDTH+2].
//  - Read path is fully combinational with zero latency. Compare all ways of
//    set[rd index]; hit = valid & tag equal.
//  - At most one way may match; the write rules guarantee this.
//    If several ways match anyway, the lowest-numbered way wins.
//  - Write takes effect on the rising edge. A same-cycle read of the same set returns
//    the pre-write contents (no bypass).
//  - Write, tag hit in set[wr index] (way w): rewrite target of way w.
//    Bias and valid are kept, and the RR pointer does not move.
//  - Write, tag miss: allocate a victim = lowest-numbered invalid way.
//    If every way is valid, the victim is the way at rr_ptr[set].
//    Write tag, target and valid=1, and write bias=br_taken_i.
//    rr_ptr[set] advances by 1 mod WAYS only when the victim came from rr_ptr.
//  - WAYS=1: direct-mapped. Every miss write overwrites way 0, and rr_ptr is unused.
//  - FSM states:
//    IDLE: flush_i=1 -> FLUSH with cnt=0 (flush wins over a same-cycle wren_i, which
//    is dropped).
//    FLUSH: each cycle clear valid of all ways in set cnt, clear rr_ptr[cnt], then
//    cnt++. At cnt=TABLE_SIZE-1 return to IDLE.
//    FLUSH lasts exactly TABLE_SIZE cycles.
//  - During FLUSH: busy_o=1 and hit_o forced to 0. wren_i and flush_i are ignored
//    (no restart).
//  - Reset (async, any state, including mid-flush): all valid=0, all rr_ptr=0,
//    FSM=IDLE, cnt=0.
//    Outputs at reset: hit_o=0, rd_target_o=0, bias_o=0, hit_way_o=0, busy_o=0.
//  - Tag and target arrays are not reset, so their contents are don't-care until
//    valid is set.
// TESTING
//  1 After reset, read any PC -> hit_o=0, rd_target_o=0, busy_o=0.
//  2 Write pc=0x0000_1000, target 0x2000, taken=1; next cycle read 0x1000 ->
//    hit_o=1, rd_target_o=0x2000, bias_o=1, hit_way_o=0.
//  3 Rewrite 0x1000 with target 0x3000, taken=0 -> target=0x3000, bias_o stays 1,
//    same way.
//  4 WAYS=2, INDEX_WIDTH=6: write 0x1000, 0x2000, then 0x3000 (all index 0).
//    Expected: 0x1000 in way 0, 0x2000 in way 1, 0x3000 evicts way 0 (rr_ptr=0 -> 1).
//    A fourth tag then evicts way 1.
//  5 Fill the table, pulse flush_i with wren_i=1 the same cycle -> write dropped,
//    busy_o=1 for exactly 64 cycles. All reads miss, and wren_i is ignored meanwhile.
//  6 Assert rst_ni=0 at flush cycle 10 -> busy_o=0 immediately, all entries invalid,
//    FSM IDLE.

Source files
------------

// File: rtl/agree_btb_assoc.sv
// Set-associative branch target buffer for the agree predictor: zero-latency IF lookup,
// EX-side update/allocation (first invalid, then round-robin) and a sequenced flush FSM.
module agree_btb_assoc #(
   parameter  int unsigned INDEX_WIDTH = 6,
   parameter  int unsigned WAYS        = 2,
   localparam int unsigned WAY_W       = (WAYS > 1) ? $clog2(WAYS) : 1
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [31:0]      rd_pc_i,
   input  logic             wren_i,
   input  logic [31:0]      wr_pc_i,
   input  logic [31:0]      wr_target_i,
   input  logic             br_taken_i,
   input  logic             flush_i,
   output logic             hit_o,
   output logic [31:0]      rd_target_o,
   output logic             bias_o,
   output logic [WAY_W-1:0] hit_way_o,
   output logic             busy_o
);

   localparam int unsigned TABLE_SIZE = 1 << INDEX_WIDTH;
   localparam int unsigned TAG_WIDTH  = 32 - INDEX_WIDTH - 2;

   typedef enum logic {
      IDLE,
      FLUSH
   } state_e;

   state_e                 state_q;
   logic [INDEX_WIDTH-1:0] cnt_q;

   logic [WAYS-1:0]        valid_q  [TABLE_SIZE];
   logic [WAYS-1:0]        bias_q   [TABLE_SIZE];
   logic [WAY_W-1:0]       rr_q     [TABLE_SIZE];
   logic [TAG_WIDTH-1:0]   tag_q    [TABLE_SIZE][WAYS];
   logic [31:0]            target_q [TABLE_SIZE][WAYS];

   logic [INDEX_WIDTH-1:0] rd_idx, wr_idx;
   logic [TAG_WIDTH-1:0]   rd_tag, wr_tag;
   logic                   wr_en;
   logic                   wr_hit;
   logic [WAY_W-1:0]       wr_hit_way;
   logic                   inv_found;
   logic [WAY_W-1:0]       inv_way;
   logic [WAY_W-1:0]       victim;
   logic [WAY_W-1:0]       wr_way;
   logic [WAY_W-1:0]       rr_adv;
   logic                   unused_pc_bits;

   assign rd_idx = rd_pc_i[INDEX_WIDTH+1:2];
   assign rd_tag = rd_pc_i[31:INDEX_WIDTH+2];
   assign wr_idx = wr_pc_i[INDEX_WIDTH+1:2];
   assign wr_tag = wr_pc_i[31:INDEX_WIDTH+2];
   assign unused_pc_bits = ^{rd_pc_i[1:0], wr_pc_i[1:0]};

   assign busy_o = (state_q == FLUSH);
   // Flush in IDLE wins over a same-cycle write; writes are ignored during FLUSH.
   assign wr_en  = (state_q == IDLE) && wren_i && !flush_i;

   // Read path: lowest-numbered matching way wins; forced miss while flushing.
   always_comb begin
      hit_o       = 1'b0;
      rd_target_o = '0;
      bias_o      = 1'b0;
      hit_way_o   = '0;
      if (state_q == IDLE) begin
         for (int unsigned w = 0; w < WAYS; w++) begin
            if (!hit_o && valid_q[rd_idx][w] && (tag_q[rd_idx][w] == rd_tag)) begin
               hit_o       = 1'b1;
               rd_target_o = target_q[rd_idx][w];
               bias_o      = bias_q[rd_idx][w];
               hit_way_o   = WAY_W'(w);
            end
         end
      end
   end

   always_comb begin
      wr_hit     = 1'b0;
      wr_hit_way = '0;
      inv_found  = 1'b0;
      inv_way    = '0;
      for (int unsigned w = 0; w < WAYS; w++) begin
         if (!wr_hit && valid_q[wr_idx][w] && (tag_q[wr_idx][w] == wr_tag)) begin
            wr_hit     = 1'b1;
            wr_hit_way = WAY_W'(w);
         end
         if (!inv_found && !valid_q[wr_idx][w]) begin
            inv_found = 1'b1;
            inv_way   = WAY_W'(w);
         end
      end
      victim = inv_found ? inv_way : rr_q[wr_idx];
      wr_way = wr_hit ? wr_hit_way : victim;
      rr_adv = (rr_q[wr_idx] == WAY_W'(WAYS - 1)) ? '0 : rr_q[wr_idx] + 1'b1;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         for (int unsigned s = 0; s < TABLE_SIZE; s++) begin
            valid_q[s] <= '0;
            rr_q[s]    <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (flush_i) begin
                  state_q <= FLUSH;
                  cnt_q   <= '0;
               end else if (wr_en && !wr_hit) begin
                  valid_q[wr_idx][victim] <= 1'b1;
                  if (!inv_found) rr_q[wr_idx] <= rr_adv;
               end
            end
            FLUSH: begin
               valid_q[cnt_q] <= '0;
               rr_q[cnt_q]    <= '0;
               cnt_q          <= cnt_q + 1'b1;
               if (&cnt_q) state_q <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Payload arrays carry no reset; they are qualified by valid_q.
   always_ff @(posedge clk_i) begin
      if (wr_en) begin
         target_q[wr_idx][wr_way] <= wr_target_i;
         if (!wr_hit) begin
            tag_q[wr_idx][wr_way]  <= wr_tag;
            bias_q[wr_idx][wr_way] <= br_taken_i;
         end
      end
   end

endmodule

// File: tb/tb_agree_btb_assoc.sv
// Self-checking bench for agree_btb_assoc: directed scenarios plus randomized traffic
// compared each cycle against a behavioural set/way model.
module tb_agree_btb_assoc;

   localparam int unsigned IW    = 6;
   localparam int unsigned NW    = 2;
   localparam int unsigned NSETS = 1 << IW;

   logic        clk_i = 1'b0;
   logic        rst_ni;
   logic [31:0] rd_pc_i, wr_pc_i, wr_target_i;
   logic        wren_i, br_taken_i, flush_i;
   logic        hit_o, bias_o, busy_o;
   logic [31:0] rd_target_o;
   logic [0:0]  hit_way_o;

   always #5 clk_i = ~clk_i;

   agree_btb_assoc #(.INDEX_WIDTH(IW), .WAYS(NW)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .rd_pc_i(rd_pc_i), .wren_i(wren_i),
      .wr_pc_i(wr_pc_i), .wr_target_i(wr_target_i), .br_taken_i(br_taken_i),
      .flush_i(flush_i), .hit_o(hit_o), .rd_target_o(rd_target_o), .bias_o(bias_o),
      .hit_way_o(hit_way_o), .busy_o(busy_o)
   );

   int unsigned n_cmp = 0;
   int unsigned n_mis = 0;

   // Reference model: flush is seen as "whole table empty, busy for NSETS edges".
   bit          m_valid [NSETS][NW];
   logic [23:0] m_tag   [NSETS][NW];
   logic [31:0] m_tgt   [NSETS][NW];
   bit          m_bias  [NSETS][NW];
   int unsigned m_rr    [NSETS];
   int unsigned m_flush_left;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int s = 0; s < NSETS; s++) begin
         for (int w = 0; w < NW; w++) m_valid[s][w] = 1'b0;
         m_rr[s] = 0;
      end
      m_flush_left = 0;
   endtask

   task automatic model_read(input logic [31:0] pc, output bit h, output logic [31:0] t,
                             output bit b, output int unsigned way);
      int s;
      s = int'(pc[7:2]);
      h = 1'b0; t = '0; b = 1'b0; way = 0;
      if (m_flush_left == 0) begin
         for (int w = 0; w < NW; w++) begin
            if (!h && m_valid[s][w] && m_tag[s][w] == pc[31:8]) begin
               h = 1'b1; t = m_tgt[s][w]; b = m_bias[s][w]; way = w;
            end
         end
      end
   endtask

   task automatic model_edge();
      int s, hw, vic;
      if (m_flush_left > 0) begin
         m_flush_left--;
      end else if (flush_i) begin
         model_reset();
         m_flush_left = NSETS;
      end else if (wren_i) begin
         s  = int'(wr_pc_i[7:2]);
         hw = -1;
         for (int w = NW - 1; w >= 0; w--)
            if (m_valid[s][w] && m_tag[s][w] == wr_pc_i[31:8]) hw = w;
         if (hw >= 0) begin
            m_tgt[s][hw] = wr_target_i;
         end else begin
            vic = -1;
            for (int w = NW - 1; w >= 0; w--) if (!m_valid[s][w]) vic = w;
            if (vic < 0) begin
               vic     = m_rr[s];
               m_rr[s] = (m_rr[s] + 1) % NW;
            end
            m_valid[s][vic] = 1'b1;
            m_tag[s][vic]   = wr_pc_i[31:8];
            m_tgt[s][vic]   = wr_target_i;
            m_bias[s][vic]  = br_taken_i;
         end
      end
   endtask

   // Called at posedge+1: compare outputs mid-cycle, then advance model at the edge.
   task automatic cycle();
      bit eh, eb;
      logic [31:0] et;
      int unsigned ew;
      @(negedge clk_i);
      model_read(rd_pc_i, eh, et, eb, ew);
      check("hit", 32'(hit_o), 32'(eh));
      check("target", rd_target_o, et);
      check("bias", 32'(bias_o), 32'(eb));
      check("way", 32'(hit_way_o), ew);
      check("busy", 32'(busy_o), 32'(m_flush_left > 0));
      @(posedge clk_i);
      model_edge();
      #1;
   endtask

   task automatic drive(input bit we, input logic [31:0] wpc, input logic [31:0] wt,
                        input bit tk, input bit fl, input logic [31:0] rpc);
      wren_i = we; wr_pc_i = wpc; wr_target_i = wt; br_taken_i = tk;
      flush_i = fl; rd_pc_i = rpc;
      cycle();
   endtask

   function automatic logic [31:0] rand_pc();
      logic [23:0] tg;
      logic [5:0]  ix;
      logic [1:0]  lo;
      tg = 24'(32'h100 + $urandom_range(0, 4));
      ix = 6'($urandom_range(0, 3));
      lo = 2'($urandom_range(0, 3));
      return {tg, ix, lo};
   endfunction

   initial begin
      int unsigned busy_cnt;
      rst_ni = 1'b0; wren_i = 1'b0; wr_pc_i = '0; wr_target_i = '0;
      br_taken_i = 1'b0; flush_i = 1'b0; rd_pc_i = 32'h0000_1000;
      model_reset();
      #1;
      check("rst_hit", 32'(hit_o), 32'd0);
      check("rst_target", rd_target_o, 32'd0);
      check("rst_busy", 32'(busy_o), 32'd0);
      repeat (2) @(posedge clk_i);
      @(negedge clk_i); rst_ni = 1'b1;
      @(posedge clk_i); #1;

      // Allocate, then rewrite keeping bias and way.
      drive(1, 32'h1000, 32'h2000, 1, 0, 32'h0);
      drive(0, 0, 0, 0, 0, 32'h1000);
      rd_pc_i = 32'h1000; #1;
      check("t2_hit", 32'(hit_o), 32'd1);
      check("t2_target", rd_target_o, 32'h2000);
      check("t2_bias", 32'(bias_o), 32'd1);
      check("t2_way", 32'(hit_way_o), 32'd0);
      drive(1, 32'h1000, 32'h3000, 0, 0, 32'h1000);
      #1;
      check("t3_target", rd_target_o, 32'h3000);
      check("t3_bias", 32'(bias_o), 32'd1);
      drive(0, 0, 0, 0, 0, 32'h1000);

      // Same-set fill and round-robin eviction.
      drive(1, 32'h2000, 32'h2222, 0, 0, 32'h2000);
      drive(1, 32'h3000, 32'h3333, 1, 0, 32'h2000);
      rd_pc_i = 32'h3000; #1;
      check("t4_way3000", 32'(hit_way_o), 32'd0);
      drive(0, 0, 0, 0, 0, 32'h1000);
      drive(1, 32'h4000, 32'h4444, 0, 0, 32'h3000);
      rd_pc_i = 32'h4000; #1;
      check("t4_way4000", 32'(hit_way_o), 32'd1);
      drive(0, 0, 0, 0, 0, 32'h2000);

      // Fill table, flush with a same-cycle write, measure busy length.
      for (int s = 0; s < NSETS; s++)
         for (int w = 0; w < NW; w++)
            drive(1, {24'(32'h500 + w), 6'(s), 2'b00}, 32'(s * 16 + w), w[0], 0, 32'h0);
      drive(1, 32'h0009_9000, 32'hdead, 1, 1, 32'h0000_5000);
      busy_cnt = 0;
      for (int i = 0; i < 100 && busy_o; i++) begin
         busy_cnt++;
         drive(1, rand_pc(), $urandom, 1, $urandom_range(0, 1), {24'h500, 6'(i), 2'b00});
      end
      check("flush_len", busy_cnt, NSETS);
      drive(0, 0, 0, 0, 0, 32'h0009_9000);
      drive(0, 0, 0, 0, 0, 32'h0005_0500);

      // Reset in the middle of a flush.
      for (int s = 0; s < NSETS; s++)
         drive(1, {24'h600, 6'(s), 2'b00}, 32'(s), 1, 0, 32'h0);
      drive(0, 0, 0, 0, 1, 32'h0);
      repeat (10) drive(0, 0, 0, 0, 0, {24'h600, 6'd40, 2'b00});
      rst_ni = 1'b0; #1;
      model_reset();
      check("midrst_busy", 32'(busy_o), 32'd0);
      check("midrst_hit", 32'(hit_o), 32'd0);
      @(posedge clk_i);
      @(negedge clk_i); rst_ni = 1'b1;
      @(posedge clk_i); #1;
      drive(0, 0, 0, 0, 0, {24'h600, 6'd40, 2'b00});
      drive(0, 0, 0, 0, 0, {24'h600, 6'd2, 2'b00});

      // Randomized traffic.
      for (int i = 0; i < 1500; i++) begin
         drive($urandom_range(0, 1), rand_pc(), $urandom, $urandom_range(0, 1),
               $urandom_range(0, 59) == 0, rand_pc());
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
